// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, tile geometry and the RGB332 expansion helper.
// Optional tile-grid overlay in the top is enabled by defining TILE_GRID_EN.
package vga_pkg;

   localparam logic [9:0] H_ACTIVE = 10'd640;
   localparam logic [9:0] H_FP     = 10'd16;
   localparam logic [9:0] H_SYNC   = 10'd96;
   localparam logic [9:0] H_BP     = 10'd48;
   localparam logic [9:0] V_ACTIVE = 10'd480;
   localparam logic [9:0] V_FP     = 10'd10;
   localparam logic [9:0] V_SYNC   = 10'd2;
   localparam logic [9:0] V_BP     = 10'd33;

   localparam logic [9:0] H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam logic [9:0] V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
   localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
   localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
   localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

   localparam logic [5:0] TILE_W  = 6'd40;
   localparam logic [4:0] TILE_H  = 5'd24;
   localparam int         TILES_X = 16;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb24_t;

   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } vga_flags_t;

   // Bit replication keeps full-scale codes at 0xFF and zero at 0x00.
   function automatic rgb24_t rgb332_expand(input logic [7:0] p);
      rgb24_t c;
      c.r = {p[7:5], p[7:5], p[7:6]};
      c.g = {p[4:2], p[4:2], p[4:3]};
      c.b = {p[1:0], p[1:0], p[1:0], p[1:0]};
      return c;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Width-generic shift register of DEPTH stages, every stage clearing to zero on reset.
module vga_delay_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [DEPTH-1:0][WIDTH-1:0] pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe <= '0;
      end else begin
         pipe[0] <= din;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/vga_scan_out.sv
// VGA raster counters, sync/blank generation aligned to frame-buffer read latency, RGB332 expansion.
// Define TILE_GRID_EN to overlay the 40x24 tile grid in white.
module vga_scan_out
   import vga_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] h_count,
   output logic [9:0] v_count,
   input  logic [7:0] pixel_data,
   output logic       frame_start,
   output logic       vga_hs_n,
   output logic       vga_vs_n,
   output logic       vga_blank_n,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b
);

   logic       run;
   logic       hWrap, vWrap;
   vga_flags_t flags0, flagsD;
   rgb24_t     rgbNext, rgbOut;

   assign hWrap = (h_count == H_TOTAL - 10'd1);
   assign vWrap = (v_count == V_TOTAL - 10'd1);

   // The first cycle after reset holds (0,0) and raises frame_start; counting starts after it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run         <= 1'b0;
         h_count     <= '0;
         v_count     <= '0;
         frame_start <= 1'b0;
      end else if (!run) begin
         run         <= 1'b1;
         frame_start <= 1'b1;
      end else begin
         h_count     <= hWrap ? 10'd0 : h_count + 10'd1;
         if (hWrap) v_count <= vWrap ? 10'd0 : v_count + 10'd1;
         frame_start <= hWrap && vWrap;
      end
   end

   always_comb begin
      flags0.active = run && (h_count < H_ACTIVE) && (v_count < V_ACTIVE);
      flags0.hs     = run && (h_count >= H_SYNC_START) && (h_count <= H_SYNC_END);
      flags0.vs     = run && (v_count >= V_SYNC_START) && (v_count <= V_SYNC_END);
   end

   vga_delay_line #(.DEPTH(READ_LATENCY), .WIDTH($bits(vga_flags_t))) flagDelay (
      .clk (clk),
      .rst (rst),
      .din (flags0),
      .dout(flagsD)
   );

`ifdef TILE_GRID_EN
   logic [5:0] tx;
   logic [4:0] ty;
   logic       grid0, gridD;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx <= '0;
         ty <= '0;
      end else if (run) begin
         tx <= (hWrap || tx == TILE_W - 6'd1) ? 6'd0 : tx + 6'd1;
         if (hWrap) ty <= (vWrap || ty == TILE_H - 5'd1) ? 5'd0 : ty + 5'd1;
      end
   end

   assign grid0 = run && (tx == 6'd0 || ty == 5'd0);

   vga_delay_line #(.DEPTH(READ_LATENCY), .WIDTH(1)) gridDelay (
      .clk (clk),
      .rst (rst),
      .din (grid0),
      .dout(gridD)
   );
`endif

   always_comb begin
      rgbNext = '0;
      if (flagsD.active) begin
`ifdef TILE_GRID_EN
         rgbNext = gridD ? 24'hFFFFFF : rgb332_expand(pixel_data);
`else
         rgbNext = rgb332_expand(pixel_data);
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga_hs_n    <= 1'b1;
         vga_vs_n    <= 1'b1;
         vga_blank_n <= 1'b0;
         rgbOut      <= '0;
      end else begin
         vga_hs_n    <= ~flagsD.hs;
         vga_vs_n    <= ~flagsD.vs;
         vga_blank_n <= flagsD.active;
         rgbOut      <= rgbNext;
      end
   end

   assign vga_r = rgbOut.r;
   assign vga_g = rgbOut.g;
   assign vga_b = rgbOut.b;

endmodule

// File: tb/tb_vga_scan_out.sv
// Randomised check of vga_scan_out against a raster-position model (READ_LATENCY=1, latency 2).
// Compile with TILE_GRID_EN to check the grid overlay build.
module tb_vga_scan_out;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] h_count, v_count;
   logic [7:0] pixel_data;
   logic       frame_start, vga_hs_n, vga_vs_n, vga_blank_n;
   logic [7:0] vga_r, vga_g, vga_b;

   int total = 0;
   int bad   = 0;
   logic [7:0] pix [0:40000];

   vga_scan_out #(.READ_LATENCY(1)) dut (
      .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
      .pixel_data(pixel_data), .frame_start(frame_start),
      .vga_hs_n(vga_hs_n), .vga_vs_n(vga_vs_n), .vga_blank_n(vga_blank_n),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
   );

   always #20 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic checkReset();
      chk("rst_h", 32'(h_count), 0);
      chk("rst_v", 32'(v_count), 0);
      chk("rst_fs", 32'(frame_start), 0);
      chk("rst_hs_n", 32'(vga_hs_n), 1);
      chk("rst_vs_n", 32'(vga_vs_n), 1);
      chk("rst_blank_n", 32'(vga_blank_n), 0);
      chk("rst_rgb", {8'h0, vga_r, vga_g, vga_b}, 0);
   endtask

   // Cycle t counts from the first cycle after reset release, which shows raster (0,0).
   task automatic checkCycle(input int t);
      int n, h, v;
      logic [7:0] p;
      logic [23:0] eRgb;
      logic eHs, eVs, eVis;
      chk("h", 32'(h_count), t % 800);
      chk("v", 32'(v_count), (t / 800) % 525);
      chk("fs", 32'(frame_start), (t % 420000) == 0);
      if (t < 2) begin
         eHs = 1'b0; eVs = 1'b0; eVis = 1'b0; eRgb = '0;
      end else begin
         n = t - 2;
         h = n % 800;
         v = (n / 800) % 525;
         eHs  = (h >= 656 && h <= 751);
         eVs  = (v == 490 || v == 491);
         eVis = (h < 640 && v < 480);
         p    = pix[t-1];
         eRgb = '0;
         if (eVis) begin
            eRgb = {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
`ifdef TILE_GRID_EN
            if (h % 40 == 0 || v % 24 == 0) eRgb = 24'hFFFFFF;
`endif
         end
      end
      chk("hs_n", 32'(vga_hs_n), 32'(!eHs));
      chk("vs_n", 32'(vga_vs_n), 32'(!eVs));
      chk("blank_n", 32'(vga_blank_n), 32'(eVis));
      chk("rgb", {8'h0, vga_r, vga_g, vga_b}, {8'h0, eRgb});
   endtask

   // Pixel driven in cycle t is the read result for raster position t-1.
   function automatic logic [7:0] choosePix(input int t);
      int n, h, v;
      n = t - 1;
      h = n % 800;
      v = n / 800;
      if (n < 0) return 8'($urandom);
      if (v == 1 && h == 0) return 8'hE0;
      if (v == 1 && h == 1) return 8'h1C;
      if (v == 1 && h == 2) return 8'h03;
      if (v == 2) return 8'hFF;
      if (v == 5 && (h == 40 || h == 41)) return 8'h00;
      if (v == 24 && h == 3) return 8'h00;
      return 8'($urandom);
   endfunction

   task automatic runPhase(input int cycles);
      for (int t = 0; t < cycles; t++) begin
         @(negedge clk);
         checkCycle(t);
         pix[t] = choosePix(t);
         pixel_data = pix[t];
      end
   endtask

   initial begin
      rst = 1'b1;
      pixel_data = 8'h00;
      repeat (3) @(negedge clk);
      checkReset();
      rst = 1'b0;

      // Run up to raster (300,20), then abort the frame with a 3-cycle reset.
      runPhase(20 * 800 + 301);
      rst = 1'b1;
      #1 checkReset();
      repeat (3) begin
         @(negedge clk);
         checkReset();
      end
      rst = 1'b0;

      runPhase(26 * 800);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
